// File: rtl/mem_fetch_if.sv
// -----------------------------------------------------------------------------
// mem_fetch_if
//
// Bundles the cache-side miss request and the external half-word memory bus
// used by mem_fetch.
//
//   address_enable  miss request from the cache, held until data_valid
//   address         byte address of the requested word (bits [1:0] unused)
//   data_valid      one-cycle pulse, data is valid in this cycle
//   data            fetched 32-bit word (low half from the even half-word)
//   mem_read        read strobe to external memory
//   mem_address     half-word address {address[ADDR_W:2], phase}
//   mem_data        16-bit read data returned by memory
//   mem_wait        memory stall, stretches the current phase while high
//   bus_error       sticky timeout flag, cleared only by reset
//
// Modports:
//   master  the fetch engine: masters the memory bus, answers the cache
//   slave   the environment: cache request plus memory responses
// -----------------------------------------------------------------------------
interface mem_fetch_if #(
    parameter int ADDR_W = 20
);
    typedef logic [31:0] regval_t;

    logic              address_enable;
    regval_t           address;
    logic              data_valid;
    regval_t           data;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_data;
    logic              mem_wait;
    logic              bus_error;

    modport master (
        input  address_enable,
        input  address,
        input  mem_data,
        input  mem_wait,
        output data_valid,
        output data,
        output mem_read,
        output mem_address,
        output bus_error
    );

    modport slave (
        output address_enable,
        output address,
        output mem_data,
        output mem_wait,
        input  data_valid,
        input  data,
        input  mem_read,
        input  mem_address,
        input  bus_error
    );
endinterface

// File: rtl/mem_fetch.sv
// -----------------------------------------------------------------------------
// mem_fetch
//
// Memory-side fill engine for the cache. A held miss request is turned into
// two sequential 16-bit reads (even half-word first, then odd), the halves are
// assembled into one 32-bit word and returned with a single-cycle data_valid
// strobe. Each phase lasts WAIT+1 cycles plus any mem_wait stretching, and a
// phase held by mem_wait for more than TIMEOUT cycles is forced to finish with
// a zero half and a sticky bus_error.
//
// Parameters:
//   WAIT     base wait cycles per half-word read (phase >= WAIT+1 cycles)
//   ADDR_W   half-word address width of the memory bus
//   TIMEOUT  max consecutive mem_wait cycles after the base wait expires
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-high reset
//   bus      mem_fetch_if.master (request, response and memory bus signals)
// -----------------------------------------------------------------------------
module mem_fetch #(
    parameter int WAIT    = 2,
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    mem_fetch_if.master  bus
);
    // A zero-width counter is illegal, so WAIT=0 still gets one bit.
    localparam int CNT_W   = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam int TO_BITS = $clog2(TIMEOUT + 1);
    localparam int TO_W    = (TO_BITS > 8) ? TO_BITS : 8;

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Registered state
    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [ADDR_W-2:0]  line_q;
    logic [31:0]        data_q;
    logic               data_valid_q;
    logic               mem_read_q;
    logic [ADDR_W-1:0]  mem_address_q;
    logic               bus_error_q;

    // Next-state values
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt_d;
    logic [TO_W-1:0]    to_cnt_d;
    logic [ADDR_W-2:0]  line_d;
    logic [31:0]        data_d;
    logic               data_valid_d;
    logic               mem_read_d;
    logic [ADDR_W-1:0]  mem_address_d;
    logic               bus_error_d;

    // Phase status decoded from the current registers and inputs
    logic [ADDR_W-2:0]  req_line;
    logic               base_done;
    logic               stalled;
    logic               timed_out;
    logic               phase_end;
    logic               abort;
    logic [15:0]        capture;

    // Only the word-aligned half-word line participates; bits above ADDR_W and
    // the byte offset are deliberately ignored.
    assign req_line  = bus.address[ADDR_W:2];

    assign base_done = (wait_cnt_q == '0);
    // mem_wait only matters once the base wait has expired.
    assign stalled   = base_done && bus.mem_wait;
    assign timed_out = stalled && (to_cnt_q == TO_LIMIT);
    assign phase_end = base_done && (!bus.mem_wait || timed_out);
    assign capture   = timed_out ? 16'h0000 : bus.mem_data;
    assign abort     = !bus.address_enable || (req_line != line_q);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        to_cnt_d      = to_cnt_q;
        line_d        = line_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        bus_error_d   = bus_error_q;

        unique case (state_q)
            IDLE: begin
                if (bus.address_enable) begin
                    line_d        = req_line;
                    wait_cnt_d    = WAIT_LOAD;
                    to_cnt_d      = '0;
                    mem_read_d    = 1'b1;
                    mem_address_d = {req_line, 1'b0};
                    state_d       = LOW;
                end
            end

            LOW, HIGH: begin
                if (abort) begin
                    // Withdrawn or retargeted request: drop it without a
                    // data_valid; a new address is picked up again from IDLE.
                    wait_cnt_d = '0;
                    to_cnt_d   = '0;
                    mem_read_d = 1'b0;
                    state_d    = IDLE;
                end else if (phase_end) begin
                    to_cnt_d = '0;
                    if (timed_out) begin
                        bus_error_d = 1'b1;
                    end
                    if (state_q == LOW) begin
                        data_d[15:0]  = capture;
                        wait_cnt_d    = WAIT_LOAD;
                        mem_address_d = {line_q, 1'b1};
                        state_d       = HIGH;
                    end else begin
                        data_d[31:16] = capture;
                        wait_cnt_d    = '0;
                        mem_read_d    = 1'b0;
                        data_valid_d  = 1'b1;
                        state_d       = DONE;
                    end
                end else if (!base_done) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else begin
                    // Stalled after the base wait; the timeout check above
                    // finishes the phase before this can pass TO_LIMIT.
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            DONE: begin
                // data_valid was raised on entry and drops here regardless of
                // address_enable; the cache ignores it when not requesting.
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            to_cnt_q      <= '0;
            line_q        <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            bus_error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            to_cnt_q      <= to_cnt_d;
            line_q        <= line_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            bus_error_q   <= bus_error_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.data_valid  = data_valid_q;
    assign bus.data        = data_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = mem_address_q;
    assign bus.bus_error   = bus_error_q;

endmodule
